// File: rtl/layer_controller.sv
// Sequencer for one fully-connected layer: per-neuron clear/accumulate/write loop with stall, abort and layer-done pulse.
// Optional bias beat per neuron when BIAS_CYCLE_EN is defined.
module layer_controller #(
  parameter int N_INPUTS  = 8,
  parameter int N_NEURONS = 4,
  localparam int IDX_W = $clog2(N_INPUTS + 1),
  localparam int NRN_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  output logic [IDX_W-1:0] in_idx,
  output logic [NRN_W-1:0] nrn_idx,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             bias_sel,
  output logic             out_we,
  output logic [NRN_W-1:0] out_idx,
  output logic             busy,
  output logic             ready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ACCUM = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

`ifdef BIAS_CYCLE_EN
  localparam logic [IDX_W-1:0] LAST_IN = IDX_W'(N_INPUTS);
`else
  localparam logic [IDX_W-1:0] LAST_IN = IDX_W'(N_INPUTS - 1);
`endif
  localparam logic [NRN_W-1:0] LAST_NRN = NRN_W'(N_NEURONS - 1);

  state_t state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      in_idx  <= '0;
      nrn_idx <= '0;
    end else if (abort && (state != IDLE)) begin
      // Abort outranks every transition, including completion in WRITE/DONE.
      state   <= IDLE;
      in_idx  <= '0;
      nrn_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state   <= CLEAR;
            in_idx  <= '0;
            nrn_idx <= '0;
          end
        end
        CLEAR: begin
          state  <= ACCUM;
          in_idx <= '0;
        end
        ACCUM: begin
          if (in_valid) begin
            if (in_idx == LAST_IN) state  <= WRITE;
            else                   in_idx <= in_idx + 1'b1;
          end
        end
        WRITE: begin
          if (nrn_idx == LAST_NRN) begin
            state <= DONE;
          end else begin
            state   <= CLEAR;
            nrn_idx <= nrn_idx + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign acc_clr = (state == CLEAR);
  assign acc_en  = (state == ACCUM) && in_valid;
  assign out_we  = (state == WRITE);
  assign out_idx = nrn_idx;
  assign busy    = (state != IDLE);
  assign ready   = (state == DONE);

`ifdef BIAS_CYCLE_EN
  assign bias_sel = (state == ACCUM) && (in_idx == IDX_W'(N_INPUTS));
`else
  assign bias_sel = 1'b0;
`endif

endmodule

// File: tb/tb_layer_controller.sv
// Scoreboard bench for layer_controller: the driver pushes expected strobe events, a monitor pops and compares them.
module tb_layer_controller;

  localparam int N_IN = 4;
`ifdef BIAS_CYCLE_EN
  localparam int N_NEU = 2;
  localparam int BEATS = N_IN + 1;
`else
  localparam int N_NEU = 3;
  localparam int BEATS = N_IN;
`endif
  localparam int IDX_W = $clog2(N_IN + 1);
  localparam int NRN_W = (N_NEU > 1) ? $clog2(N_NEU) : 1;

  localparam int K_CLR = 8;
  localparam int K_ACC = 4;
  localparam int K_WR  = 2;
  localparam int K_RDY = 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             in_valid = 1'b0;
  logic [IDX_W-1:0] in_idx;
  logic [NRN_W-1:0] nrn_idx;
  logic             acc_clr, acc_en, bias_sel, out_we, busy, ready;
  logic [NRN_W-1:0] out_idx;

  layer_controller #(.N_INPUTS(N_IN), .N_NEURONS(N_NEU)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .in_valid(in_valid),
    .in_idx(in_idx), .nrn_idx(nrn_idx), .acc_clr(acc_clr), .acc_en(acc_en),
    .bias_sel(bias_sel), .out_we(out_we), .out_idx(out_idx), .busy(busy), .ready(ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int nrn;
    int idx;
    int bias;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  acc_cnt = 0;
  int  cyc = 0;
  bit  hold_start = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Monitor: every strobe cycle must match the oldest expected event.
  always @(negedge clk) begin
    if (rst) begin
      int kind;
      kind = {acc_clr, acc_en, out_we, ready};
      if (acc_en) acc_cnt++;
      if (kind != 0) begin
        if (sb.size() == 0) begin
          chk("unexpected_strobe", kind, 0);
        end else begin
          ev_t e;
          e = sb.pop_front();
          chk("strobe_kind", kind, e.kind);
          case (e.kind)
            K_CLR: chk("clr_nrn", int'(nrn_idx), e.nrn);
            K_ACC: begin
              chk("acc_nrn", int'(nrn_idx), e.nrn);
              chk("acc_in_idx", int'(in_idx), e.idx);
              chk("acc_bias_sel", int'(bias_sel), e.bias);
            end
            K_WR:  chk("wr_out_idx", int'(out_idx), e.nrn);
            K_RDY: begin
              chk("rdy_nrn", int'(nrn_idx), N_NEU - 1);
              chk("rdy_busy", int'(busy), 1);
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Drives one layer; stops (cut=1) just before beat cut_beat of neuron cut_nrn, leaving the DUT in ACCUM.
  task automatic run_layer(input int stall_pct, input int cut_nrn, input int cut_beat, output bit cut);
    int stalls;
    int acc0;
    int exp_lat;
    stalls = 0;
    acc0   = acc_cnt;
    cut    = 1'b0;
    start  = 1'b1;
    abort  = 1'b0;
    in_valid = 1'($urandom_range(1));
    step();
    cyc = 1;  // the edge that sampled start counts as cycle 1
    if (!hold_start) start = 1'b0;
    for (int n = 0; n < N_NEU; n++) begin
      sb.push_back('{K_CLR, n, 0, 0});
      in_valid = 1'($urandom_range(1));
      step();
      for (int i = 0; i < BEATS; i++) begin
        for (int s = 0; s < 3 && $urandom_range(99) < stall_pct; s++) begin
          in_valid = 1'b0;
          chk("stall_in_idx_frozen", int'(in_idx), i);
          stalls++;
          step();
        end
        if (n == cut_nrn && i == cut_beat) begin
          cut = 1'b1;
          return;
        end
        in_valid = 1'b1;
        sb.push_back('{K_ACC, n, i, (i == N_IN) ? 1 : 0});
        step();
      end
      sb.push_back('{K_WR, n, 0, 0});
      in_valid = 1'($urandom_range(1));
      step();
    end
    sb.push_back('{K_RDY, 0, 0, 0});
    in_valid = 1'b0;
    exp_lat = N_NEU * (BEATS + 2) + 1 + stalls;
    while (!ready && cyc < exp_lat + 4) step();
    chk("ready_seen", int'(ready), 1);
    chk("latency", cyc, exp_lat);
    chk("acc_en_pulses", acc_cnt - acc0, N_NEU * BEATS);
    step();
    chk("busy_after_done", int'(busy), 0);
    chk("sb_empty_after_layer", sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit cut;
    // Reset state
    step();
    step();
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_idx", int'(in_idx), 0);
    chk("rst_nrn_idx", int'(nrn_idx), 0);
    chk("rst_strobes", int'({acc_clr, acc_en, out_we, ready, bias_sel}), 0);
    rst = 1'b1;
    step();

    // Full layer without stalls, then with random stalls
    run_layer(0, -1, 0, cut);
    run_layer(35, -1, 0, cut);

    // Abort during neuron 1 at in_idx 2
    run_layer(20, 1, 2, cut);
    chk("abort_point_in_idx", int'(in_idx), 2);
    abort = 1'b1;
    in_valid = 1'b0;
    step();
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_in_idx", int'(in_idx), 0);
    chk("abort_nrn_idx", int'(nrn_idx), 0);
    repeat (3) step();
    chk("abort_sb_empty", sb.size(), 0);
    run_layer(0, -1, 0, cut);

    // start held high through a layer starts a second one after ready
    hold_start = 1'b1;
    run_layer(0, -1, 0, cut);
    hold_start = 1'b0;
    run_layer(10, -1, 0, cut);

    // start together with abort in IDLE is ignored
    start = 1'b1;
    abort = 1'b1;
    step();
    chk("start_abort_idle_busy", int'(busy), 0);
    step();
    chk("start_abort_idle_busy2", int'(busy), 0);
    start = 1'b0;
    abort = 1'b0;

    // Asynchronous reset mid-ACCUM
    run_layer(0, 0, 2, cut);
    in_valid = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_acc_en", int'(acc_en), 0);
    chk("arst_in_idx", int'(in_idx), 0);
    chk("arst_nrn_idx", int'(nrn_idx), 0);
    chk("arst_strobes", int'({acc_clr, out_we, ready, bias_sel}), 0);
    sb.delete();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'($urandom_range(1));
      step();
      chk("idle_busy", int'(busy), 0);
    end
    in_valid = 1'b0;

    // Further randomized layers
    for (int r = 0; r < 4; r++) run_layer(int'($urandom_range(50)), -1, 0, cut);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer_controller.md
Name: layer_controller

Overview:
- Sequencer for one fully-connected layer of N_NEURONS neurons, each with N_INPUTS weighted inputs.
- Drives the shared accumulator with clear and enable, plus input/weight indices, and the activation-output write strobe.
- Signals layer completion to the network-level controller.
- Adds over the single-neuron controller: a multi-neuron loop, an in_valid stall handshake, abort, and an optional bias beat.

Parameters:
N_INPUTS, 8, inputs (weights) per neuron; must be >= 1
N_NEURONS, 4, neurons in the layer; must be >= 1
IDX_W, $clog2(N_INPUTS+1), width of in_idx (derived; do not override)
NRN_W, (N_NEURONS>1 ? $clog2(N_NEURONS) : 1), width of nrn_idx/out_idx (derived)

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous, active-low reset (rst=0 resets immediately; release synchronous to clk by system)
start  in  1  level-sampled start request; acted on only in IDLE
abort  in  1  synchronous abort; returns to IDLE next edge
in_valid  in  1  current input/weight pair is valid; stalls accumulation when low
in_idx  out  IDX_W  index of input/weight being accumulated
nrn_idx  out  NRN_W  neuron currently being computed
acc_clr  out  1  clear accumulator (1 cycle per neuron)
acc_en  out  1  accumulate this cycle (= in_valid while in ACCUM)
bias_sel  out  1  current beat is the bias beat (0 when BIAS_CYCLE_EN is undefined)
out_we  out  1  write accumulator result to activation buffer
out_idx  out  NRN_W  write address for out_we (= nrn_idx)
busy  out  1  high in every state except IDLE
ready  out  1  one-cycle pulse: layer complete

Behaviour:
- Reset (rst=0): state=IDLE; in_idx=0, nrn_idx=0, acc_clr=0, acc_en=0, bias_sel=0, out_we=0, busy=0, ready=0.
- FSM states: IDLE, CLEAR, ACCUM, WRITE, DONE. State is registered; outputs are decoded from state/counters (Moore), except acc_en = (state==ACCUM) & in_valid.
- IDLE: start=1 and abort=0 -> CLEAR, nrn_idx<=0, in_idx<=0. Otherwise stay.
- CLEAR: acc_clr=1 for exactly 1 cycle -> ACCUM, in_idx<=0.
- ACCUM: a beat is accepted on each cycle with in_valid=1, and then in_idx increments. in_valid=0 holds all state and in_idx. Accepting the beat with in_idx==LAST -> WRITE. LAST=N_INPUTS-1, or N_INPUTS with the optional feature.
- WRITE: out_we=1, out_idx=nrn_idx for 1 cycle. If nrn_idx==N_NEURONS-1 -> DONE; else nrn_idx+1 -> CLEAR.
- DONE: ready=1 for 1 cycle -> IDLE. nrn_idx and in_idx hold their final values until the next start.
- start while busy is ignored; no queueing.
- abort=1 in any non-IDLE state -> IDLE on the next edge, counters reset to 0, no out_we/ready that cycle.
  - Abort has priority over all transitions, including start in IDLE and completion in WRITE/DONE.
- Counters never wrap; terminal comparisons use ==.
- N_INPUTS=1: ACCUM lasts one accepted beat.
- N_NEURONS=1: WRITE goes straight to DONE.
- Latency with in_valid held 1: start sampled -> ready high after N_NEURONS*(N_INPUTS+2)+1 cycles (N_INPUTS+3 per neuron with the bias beat). Each in_valid=0 cycle in ACCUM adds exactly 1 cycle.
- rst asserted mid-layer: immediate return to reset values; no further strobes.

Optional Feature:
- Macro BIAS_CYCLE_EN.
- Defined:
  - ACCUM runs one extra beat with in_idx==N_INPUTS and bias_sel=1, so the accumulator adds the neuron bias.
  - The bias beat is also gated by in_valid.
  - Per-neuron cost is N_INPUTS+3 cycles.
- Undefined:
  - bias_sel is tied 0.
  - in_idx never exceeds N_INPUTS-1.
  - The port list is unchanged.

Test Plan:
- Reset/idle: rst=0 mid-ACCUM (N_INPUTS=4, N_NEURONS=3) -> all outputs 0 immediately. After release with start=0 for 10 cycles -> busy=0, no strobes.
- Full layer, no stalls: N_INPUTS=4, N_NEURONS=3, in_valid=1, start pulse.
  - Sequence of 3x [acc_clr, 4x acc_en with in_idx 0..3, out_we with out_idx 0/1/2].
  - ready high exactly 19 cycles after start sampled; busy falls with ready.
- Stalls: same config, in_valid=0 on 5 ACCUM cycles -> ready at cycle 24. in_idx frozen during stalls; acc_en=0 on them; exactly 12 acc_en pulses total.
- Abort: abort=1 during neuron 1, in_idx=2 -> IDLE next cycle, counters 0, no out_we for neuron 1, no ready. A following start runs a complete clean layer.
- Start ignored/priority: start held high through an entire layer -> a second layer begins the cycle after ready. start=1 and abort=1 together in IDLE -> stays IDLE.
- BIAS_CYCLE_EN defined, N_INPUTS=4, N_NEURONS=2, in_valid=1:
  - in_idx runs 0..4; bias_sel=1 only at in_idx=4.
  - ready at cycle 15; exactly 10 acc_en pulses.
